// File: rtl/sha_arbiter.sv
// -----------------------------------------------------------------------------
// sha_arbiter
//   Shares a single SHA core between NREQ requesters. Pending requests are
//   granted round-robin. The winner's message is latched and presented to the
//   core, and a one-cycle start pulse is issued. The digest is captured when
//   the core reports ready. If the core has not finished after TMO busy
//   cycles, a watchdog ends the job with a zero digest and an error flag. The
//   result is held for the owner until the owner acknowledges it.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset (shared with the core)
//   Req        in   [NREQ]      per-requester job request (level)
//   Msg        in   [NREQ*DW]   requester i message at [i*DW +: DW]
//   Ack        in   [NREQ]      per-requester result acknowledge
//   Gnt        out  [NREQ]      one-hot owner of the core (START..DONE)
//   Valid      out  [NREQ]      one-hot result available (DONE)
//   Hash       out  [HW]        digest of the finished job (0 on abort)
//   Err        out              with Valid: job aborted by the watchdog
//   CoreData   out  [DW]        latched message presented to the core
//   CoreEnable out              one-cycle start pulse to the core
//   CoreHash   in   [HW]        core digest
//   CoreReady  in               core done, one-cycle pulse
// -----------------------------------------------------------------------------
module sha_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 512,
    parameter int HW   = 256,
    parameter int TMO  = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    Req,
    input  logic [NREQ*DW-1:0] Msg,
    input  logic [NREQ-1:0]    Ack,
    output logic [NREQ-1:0]    Gnt,
    output logic [NREQ-1:0]    Valid,
    output logic [HW-1:0]      Hash,
    output logic               Err,
    output logic [DW-1:0]      CoreData,
    output logic               CoreEnable,
    input  logic [HW-1:0]      CoreHash,
    input  logic               CoreReady
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(TMO);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [OW-1:0]   owner_r;
    logic [OW-1:0]   last_r;
    logic [CW-1:0]   cnt_r;
    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] valid_r;
    logic [HW-1:0]   hash_r;
    logic            err_r;
    logic [DW-1:0]   data_r;
    logic            en_r;

    logic [OW-1:0]   pick_s;
    logic            found_s;
    logic [DW-1:0]   msg_sel_s;
    logic            grant_s;
    logic            ready_s;
    logic            timeout_s;
    logic            release_s;

    // One-hot vector with bit i set.
    function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] i);
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << i;
    endfunction

    // Round-robin pick: first requesting index after last_r, wrapping around.
    always_comb begin
        logic [OW:0]   sum_v;
        logic [OW-1:0] cand_v;
        pick_s  = {OW{1'b0}};
        found_s = 1'b0;
        sum_v   = {(OW+1){1'b0}};
        cand_v  = {OW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            sum_v = {1'b0, last_r} + (OW+1)'(k);
            if (sum_v >= (OW+1)'(NREQ)) begin
                sum_v = sum_v - (OW+1)'(NREQ);
            end else begin
                sum_v = sum_v;
            end
            cand_v = sum_v[OW-1:0];
            if (!found_s && Req[cand_v]) begin
                found_s = 1'b1;
                pick_s  = cand_v;
            end else begin
                pick_s  = pick_s;
            end
        end
    end

    // Message slice of the requester being picked.
    always_comb begin
        msg_sel_s = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (pick_s == OW'(i)) begin
                msg_sel_s = Msg[i*DW +: DW];
            end else begin
                msg_sel_s = msg_sel_s;
            end
        end
    end

    // Next-state decode and per-state event strobes.
    always_comb begin
        state_s   = state_r;
        grant_s   = 1'b0;
        ready_s   = 1'b0;
        timeout_s = 1'b0;
        release_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    grant_s = 1'b1;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_s = ST_BUSY;
            end
            ST_BUSY: begin
                // A ready pulse on the limit cycle takes precedence over the abort.
                if (CoreReady) begin
                    ready_s = 1'b1;
                    state_s = ST_DONE;
                end else if (cnt_r == CW'(TMO - 1)) begin
                    timeout_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (Ack[owner_r]) begin
                    release_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Ownership, latched message, start pulse and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r <= {OW{1'b0}};
            last_r  <= OW'(NREQ - 1);
            data_r  <= {DW{1'b0}};
            gnt_r   <= {NREQ{1'b0}};
            en_r    <= 1'b0;
        end else begin
            en_r <= grant_s;
            if (grant_s) begin
                owner_r <= pick_s;
                data_r  <= msg_sel_s;
                gnt_r   <= onehot(pick_s);
            end else if (release_s) begin
                last_r <= owner_r;
                gnt_r  <= {NREQ{1'b0}};
            end else begin
                gnt_r <= gnt_r;
            end
        end
    end

    // Watchdog counter: cleared in START, counts every BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (state_r == ST_START) begin
            cnt_r <= {CW{1'b0}};
        end else if (state_r == ST_BUSY) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Result capture; Hash persists after release until the next job ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hash_r  <= {HW{1'b0}};
            err_r   <= 1'b0;
            valid_r <= {NREQ{1'b0}};
        end else if (ready_s) begin
            hash_r  <= CoreHash;
            err_r   <= 1'b0;
            valid_r <= onehot(owner_r);
        end else if (timeout_s) begin
            hash_r  <= {HW{1'b0}};
            err_r   <= 1'b1;
            valid_r <= onehot(owner_r);
        end else if (release_s) begin
            err_r   <= 1'b0;
            valid_r <= {NREQ{1'b0}};
        end else begin
            valid_r <= valid_r;
        end
    end

    assign Gnt        = gnt_r;
    assign Valid      = valid_r;
    assign Hash       = hash_r;
    assign Err        = err_r;
    assign CoreData   = data_r;
    assign CoreEnable = en_r;

endmodule

// File: tb/tb_sha_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sha_arbiter
//   Main instance (TMO=80) is checked every cycle against a job-level model
//   and by directed literal expectations. A second instance (TMO=16) is driven
//   by a hand-timed script for the watchdog boundary.
// -----------------------------------------------------------------------------
module tb_sha_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 512;
    localparam int HW   = 256;
    localparam int TMO  = 80;
    localparam logic [HW-1:0] H_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req, ack, gnt, valid;
    logic [NREQ*DW-1:0] msg;
    logic [HW-1:0]      hash, core_hash;
    logic               err, core_en, core_ready;
    logic [DW-1:0]      core_data;

    logic [NREQ-1:0]    w_req, w_ack, w_gnt, w_valid;
    logic [HW-1:0]      w_hash, w_core_hash;
    logic               w_err, w_en, w_core_ready;
    logic [DW-1:0]      w_data;

    int total = 0;
    int bad   = 0;

    sha_arbiter #(.NREQ(NREQ), .DW(DW), .HW(HW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .Req(req), .Msg(msg), .Ack(ack),
        .Gnt(gnt), .Valid(valid), .Hash(hash), .Err(err),
        .CoreData(core_data), .CoreEnable(core_en),
        .CoreHash(core_hash), .CoreReady(core_ready)
    );

    sha_arbiter #(.NREQ(NREQ), .DW(DW), .HW(HW), .TMO(16)) dut_w (
        .clk(clk), .rst(rst), .Req(w_req), .Msg(msg), .Ack(w_ack),
        .Gnt(w_gnt), .Valid(w_valid), .Hash(w_hash), .Err(w_err),
        .CoreData(w_data), .CoreEnable(w_en),
        .CoreHash(w_core_hash), .CoreReady(w_core_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int i, input int s);
        mk = {16{32'h5A5A0000 + 32'(i * 256 + s)}};
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    // ---------------- job-level reference model ----------------
    bit             m_active = 1'b0;
    bit             m_done   = 1'b0;
    int             m_owner  = 0;
    int             m_last   = NREQ - 1;
    int             m_age    = 0;
    logic [HW-1:0]  m_hash   = '0;
    logic           m_err    = 1'b0;
    logic [DW-1:0]  m_data   = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_active = 1'b0; m_done = 1'b0; m_owner = 0; m_last = NREQ - 1;
                m_age = 0; m_hash = '0; m_err = 1'b0; m_data = '0;
            end else if (!m_active) begin
                if (req != '0) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        if (req[(m_last + k) % NREQ]) begin
                            m_owner = (m_last + k) % NREQ;
                            break;
                        end
                    end
                    m_active = 1'b1; m_done = 1'b0; m_age = 0;
                    m_data = msg[m_owner*DW +: DW];
                end
            end else if (!m_done) begin
                // m_age counts busy cycles seen so far (0 = start cycle)
                if (m_age == 0) m_age = 1;
                else if (core_ready) begin m_hash = core_hash; m_err = 1'b0; m_done = 1'b1; end
                else if (m_age == TMO) begin m_hash = '0; m_err = 1'b1; m_done = 1'b1; end
                else m_age++;
            end else if (ack[m_owner]) begin
                m_active = 1'b0; m_done = 1'b0; m_last = m_owner; m_err = 1'b0;
            end
        end
    end

    // Every-cycle comparison of the main instance against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("gnt",   gnt,   m_active ? (4'b0001 << m_owner) : 4'b0000);
            check("valid", valid, m_done   ? (4'b0001 << m_owner) : 4'b0000);
            check("err",   err,   m_err);
            check("hash",  hash,  m_hash);
            check("coredata", core_data, m_data);
            check("coreen", core_en, m_active && !m_done && (m_age == 0));
        end
    end

    // Grant-order and start-pulse monitor.
    int             gq[$];
    int             en_count = 0;
    logic [NREQ-1:0] prev_gnt = '0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (gnt != '0 && prev_gnt == '0) gq.push_back(idx_of(gnt));
            if (core_en) en_count++;
            prev_gnt = gnt;
        end
    end

    // Core model: answers core_lat cycles after the start pulse (0 = never).
    int   core_lat    = 5;
    int   cd          = 0;
    logic force_ready = 1'b0;
    initial begin
        core_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                cd = 0;
                core_ready = force_ready;
            end else begin
                logic fire;
                fire = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) fire = 1'b1;
                end
                if (core_en && core_lat > 0) cd = core_lat;
                core_ready = fire | force_ready;
            end
        end
    end

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (valid == 4'b0000 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", valid != 4'b0000, 1'b1);
    endtask

    task automatic ack_owner();
        ack = valid;
        @(negedge clk);
        ack = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int cyc, en_base;
        int exp2[5];
        int exp3[4];
        logic [DW-1:0] old_m;
        exp2 = '{0, 1, 2, 3, 0};
        exp3 = '{1, 3, 0, 1};
        req = '0; ack = '0; core_hash = '0;
        w_req = '0; w_ack = '0; w_core_ready = 1'b0;
        w_core_hash = 256'hFEEDC0DE_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
        for (int i = 0; i < NREQ; i++) msg[i*DW +: DW] = mk(i, 0);
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_hash", hash, 256'd0);
        rst = 1'b1;

        // 1: single job with a 64-cycle core
        core_lat = 64; core_hash = H_ABC; en_base = en_count;
        @(negedge clk); req = 4'b0001;
        @(negedge clk);
        check("t1_gnt", gnt, 4'b0001);
        check("t1_en", core_en, 1'b1);
        req = 4'b0000;
        cyc = 0;
        while (valid == 4'b0000 && cyc < 200) begin @(negedge clk); cyc++; end
        check("t1_latency", cyc, 65);
        check("t1_valid", valid, 4'b0001);
        check("t1_hash", hash, H_ABC);
        check("t1_err", err, 1'b0);
        check("t1_en_count", en_count - en_base, 1);
        ack_owner();
        check("t1_rel_gnt", gnt, 4'b0000);
        check("t1_rel_valid", valid, 4'b0000);
        check("t1_rel_en", core_en, 1'b0);

        // 2: all requesting after reset
        core_lat = 3; core_hash = {8{32'h22220000}};
        do_reset();
        gq.delete();
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin wait_valid(50); ack_owner(); end
        req = 4'b0000;
        repeat (3) @(negedge clk);
        check("t2_count", gq.size(), 5);
        for (int j = 0; j < 5 && j < gq.size(); j++) check("t2_order", gq[j], exp2[j]);

        // 3: last=1 then 1011; non-owner ack in DONE ignored
        core_hash = {8{32'h33330000}};
        gq.delete();
        req = 4'b0010;
        wait_valid(50); ack_owner();
        req = 4'b1011;
        wait_valid(50);
        ack = 4'b0100;
        @(negedge clk);
        ack = 4'b0000;
        check("t3_nonowner_ack", valid, 4'b1000);
        ack_owner();
        for (int j = 0; j < 2; j++) begin wait_valid(50); ack_owner(); end
        req = 4'b0000;
        repeat (3) @(negedge clk);
        check("t3_count", gq.size(), 4);
        for (int j = 0; j < 4 && j < gq.size(); j++) check("t3_order", gq[j], exp3[j]);

        // 5: reset mid-BUSY, then fresh arbitration
        core_lat = 20;
        req = 4'b0001;
        repeat (5) @(negedge clk);
        req = 4'b0000;
        rst = 1'b0;
        #1;
        check("t5_gnt", gnt, 4'b0000);
        check("t5_valid", valid, 4'b0000);
        check("t5_err", err, 1'b0);
        check("t5_hash", hash, 256'd0);
        check("t5_data", core_data, 512'd0);
        check("t5_en", core_en, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1; core_lat = 4; core_hash = {8{32'h55550000}};
        req = 4'b0100;
        @(negedge clk);
        check("t5_gnt2", gnt, 4'b0100);
        req = 4'b0000;
        wait_valid(50); ack_owner();
        req = 4'b0101;
        @(negedge clk);
        check("t5_gnt0", gnt, 4'b0001);
        req = 4'b0000;
        wait_valid(50); ack_owner();

        // 6: message change after latch; stray ready in IDLE
        core_lat = 8; core_hash = {8{32'h66660000}};
        old_m = mk(1, 0);
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        msg[DW +: DW] = mk(1, 7);
        repeat (3) @(negedge clk);
        check("t6_data_busy", core_data, old_m);
        wait_valid(50);
        check("t6_data_done", core_data, old_m);
        ack_owner();
        force_ready = 1'b1;
        @(negedge clk);
        force_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_stray_valid", valid, 4'b0000);
        check("t6_stray_gnt", gnt, 4'b0000);

        // watchdog on the main instance (core never answers)
        core_lat = 0;
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        wait_valid(120);
        check("tmo_valid", valid, 4'b1000);
        check("tmo_err", err, 1'b1);
        check("tmo_hash", hash, 256'd0);
        ack_owner();
        check("tmo_rel_err", err, 1'b0);

        // 4: TMO=16 instance, ready on the limit cycle, then a real timeout
        w_req = 4'b0001;
        @(negedge clk);
        check("t4a_en", w_en, 1'b1);
        w_req = 4'b0000;
        repeat (16) @(negedge clk);
        check("t4a_pre_valid", w_valid, 4'b0000);
        w_core_ready = 1'b1;
        @(negedge clk);
        w_core_ready = 1'b0;
        check("t4a_valid", w_valid, 4'b0001);
        check("t4a_err", w_err, 1'b0);
        check("t4a_hash", w_hash, w_core_hash);
        w_ack = 4'b0001;
        @(negedge clk);
        w_ack = 4'b0000;
        check("t4a_rel", w_valid, 4'b0000);
        w_req = 4'b0001;
        @(negedge clk);
        check("t4b_en", w_en, 1'b1);
        w_req = 4'b0000;
        repeat (16) @(negedge clk);
        check("t4b_pre_valid", w_valid, 4'b0000);
        @(negedge clk);
        check("t4b_valid", w_valid, 4'b0001);
        check("t4b_err", w_err, 1'b1);
        check("t4b_hash", w_hash, 256'd0);
        w_ack = 4'b0001;
        @(negedge clk);
        w_ack = 4'b0000;
        check("t4b_rel", w_gnt, 4'b0000);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
